// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHOW,
    S_BLANK
  } scan_state_e;

  // Active-low segment lines: all ones is a dark digit.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/Binary_To_7Segment.sv
// Registered hex-to-7-segment decoder with active-low outputs; not reset.
module Binary_To_7Segment (
  input  logic       i_Clk,
  input  logic [3:0] i_Binary_Num,
  output logic       o_Segment_A,
  output logic       o_Segment_B,
  output logic       o_Segment_C,
  output logic       o_Segment_D,
  output logic       o_Segment_E,
  output logic       o_Segment_F,
  output logic       o_Segment_G
);

  // Bit order {A,B,C,D,E,F,G}, 0 = segment lit.
  logic [6:0] seg_q;

  always_ff @(posedge i_Clk) begin
    case (i_Binary_Num)
      4'h0:    seg_q <= 7'h01;
      4'h1:    seg_q <= 7'h4F;
      4'h2:    seg_q <= 7'h12;
      4'h3:    seg_q <= 7'h06;
      4'h4:    seg_q <= 7'h4C;
      4'h5:    seg_q <= 7'h24;
      4'h6:    seg_q <= 7'h20;
      4'h7:    seg_q <= 7'h0F;
      4'h8:    seg_q <= 7'h00;
      4'h9:    seg_q <= 7'h04;
      4'hA:    seg_q <= 7'h08;
      4'hB:    seg_q <= 7'h60;
      4'hC:    seg_q <= 7'h31;
      4'hD:    seg_q <= 7'h42;
      4'hE:    seg_q <= 7'h30;
      default: seg_q <= 7'h38;
    endcase
  end

  assign {o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
          o_Segment_E, o_Segment_F, o_Segment_G} = seg_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered digit bank
// that is committed once per frame.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 25000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_Wr_Valid,
  input  logic [$clog2(NUM_DIGITS)-1:0] i_Wr_Digit,
  input  logic [3:0]                    i_Wr_Data,
  output logic                          o_Wr_Ready,
  input  logic [NUM_DIGITS-1:0]         i_Blank_Mask,
  output logic                          o_Segment_A,
  output logic                          o_Segment_B,
  output logic                          o_Segment_C,
  output logic                          o_Segment_D,
  output logic                          o_Segment_E,
  output logic                          o_Segment_F,
  output logic                          o_Segment_G,
  output logic [NUM_DIGITS-1:0]         o_Digit_En,
  output logic                          o_Frame_Start
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned MaxCnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  scan_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            started_q;
  logic [3:0]      shadow_q [NUM_DIGITS];
  logic [3:0]      active_q [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  lit_q, lit_d;
  logic                  wr_ready_q;
  logic                  frame_start_q;
  logic                  commit, commit_next, accept, in_range;
  logic [6:0]            dec_seg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // First cycle out of reset enters digit 0's load slot.
    if (!started_q) begin
      state_d = S_LOAD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          state_d = S_SHOW;
          cnt_d   = CntW'(DWELL_CYCLES - 1);
        end
        S_SHOW: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = CntW'(BLANK_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_LOAD;
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  assign commit      = started_q && (state_q == S_BLANK) && (cnt_q == '0) && (idx_q == LastIdx);
  assign commit_next = (state_d == S_BLANK) && (cnt_d == '0) && (idx_d == LastIdx);
  assign accept      = i_Wr_Valid && wr_ready_q;
  assign in_range    = 32'(i_Wr_Digit) < NUM_DIGITS;
  assign lit_d       = (state_d == S_SHOW) && !i_Blank_Mask[idx_d];
  assign digit_en_d  = lit_d ? (NUM_DIGITS'(1) << idx_d) : '0;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q       <= S_LOAD;
      idx_q         <= '0;
      cnt_q         <= '0;
      started_q     <= 1'b0;
      digit_en_q    <= '0;
      lit_q         <= 1'b0;
      wr_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      started_q     <= 1'b1;
      digit_en_q    <= digit_en_d;
      lit_q         <= lit_d;
      wr_ready_q    <= !commit_next;
      frame_start_q <= (state_d == S_LOAD) && (idx_d == '0);
      if (accept && in_range) begin
        shadow_q[i_Wr_Digit] <= i_Wr_Data;
      end
      if (commit) begin
        active_q <= shadow_q;
      end
    end
  end

  // The decoder register absorbs its latency during S_LOAD.
  Binary_To_7Segment u_decoder (
    .i_Clk        (i_Clk),
    .i_Binary_Num (active_q[idx_q]),
    .o_Segment_A  (dec_seg[6]),
    .o_Segment_B  (dec_seg[5]),
    .o_Segment_C  (dec_seg[4]),
    .o_Segment_D  (dec_seg[3]),
    .o_Segment_E  (dec_seg[2]),
    .o_Segment_F  (dec_seg[1]),
    .o_Segment_G  (dec_seg[0])
  );

  assign {o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
          o_Segment_E, o_Segment_F, o_Segment_G} = lit_q ? dec_seg : SEG_OFF;

  assign o_Digit_En    = digit_en_q;
  assign o_Wr_Ready    = wr_ready_q;
  assign o_Frame_Start = frame_start_q;

endmodule
